// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for the multicycle RV32I core
module multicycle_ctrl #(
    parameter int OPCODE_WIDTH = 7,
    parameter int STATE_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] op,
    input  logic                    funct3_0,
    input  logic                    zero,
    input  logic                    mem_ready,
    output logic                    mem_req,
    output logic                    pc_write,
    output logic                    adr_src,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic [1:0]              result_src,
    output logic [1:0]              alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              alu_op,
    output logic                    reg_write,
    output logic [1:0]              imm_src,
    output logic                    illegal_instr,
    output logic [STATE_WIDTH-1:0]  state_dbg
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;

    localparam logic [OPCODE_WIDTH-1:0] OP_LW     = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW     = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_WIDTH-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = 7'b1101111;

    logic [3:0] state;
    logic [3:0] state_next;

    logic       mem_req_d;
    logic       pc_write_d;
    logic       adr_src_d;
    logic       mem_write_d;
    logic       ir_write_d;
    logic [1:0] result_src_d;
    logic [1:0] alu_src_a_d;
    logic [1:0] alu_src_b_d;
    logic [1:0] alu_op_d;
    logic       reg_write_d;
    logic       illegal_d;
    logic [1:0] imm_src_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = FETCH;
        mem_req_d    = 1'b0;
        pc_write_d   = 1'b0;
        adr_src_d    = 1'b0;
        mem_write_d  = 1'b0;
        ir_write_d   = 1'b0;
        result_src_d = 2'b00;
        alu_src_a_d  = 2'b00;
        alu_src_b_d  = 2'b00;
        alu_op_d     = 2'b00;
        reg_write_d  = 1'b0;
        illegal_d    = 1'b0;
        case (state)
            FETCH: begin
                mem_req_d    = 1'b1;
                alu_src_b_d  = 2'b10;
                result_src_d = 2'b10;
                ir_write_d   = mem_ready;
                pc_write_d   = mem_ready;
                state_next   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECR;
                    OP_ITYPE:     state_next = EXECI;
                    OP_BRANCH:    state_next = BRANCH;
                    OP_JAL:       state_next = JAL;
                    default: begin
                        illegal_d  = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
                state_next  = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req_d  = 1'b1;
                adr_src_d  = 1'b1;
                state_next = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src_d = 2'b01;
                reg_write_d  = 1'b1;
            end
            MEMWRITE: begin
                // Strobe held for the whole wait; memory commits on the ready cycle.
                mem_req_d   = 1'b1;
                adr_src_d   = 1'b1;
                mem_write_d = 1'b1;
                state_next  = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a_d = 2'b10;
                alu_op_d    = 2'b10;
                state_next  = ALUWB;
            end
            EXECI: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
                alu_op_d    = 2'b10;
                state_next  = ALUWB;
            end
            ALUWB: begin
                reg_write_d = 1'b1;
            end
            BRANCH: begin
                alu_src_a_d = 2'b10;
                alu_op_d    = 2'b01;
                pc_write_d  = zero ^ funct3_0;
            end
            JAL: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b10;
                pc_write_d  = 1'b1;
                reg_write_d = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:     imm_src_d = 2'b01;
            OP_BRANCH: imm_src_d = 2'b10;
            OP_JAL:    imm_src_d = 2'b11;
            default:   imm_src_d = 2'b00;
        endcase
    end

    // Gate with rst_n so nothing fires while reset is held, even though FETCH drives mem_req.
    assign mem_req       = rst_n & mem_req_d;
    assign pc_write      = rst_n & pc_write_d;
    assign adr_src       = rst_n & adr_src_d;
    assign mem_write     = rst_n & mem_write_d;
    assign ir_write      = rst_n & ir_write_d;
    assign reg_write     = rst_n & reg_write_d;
    assign illegal_instr = rst_n & illegal_d;
    assign result_src    = rst_n ? result_src_d : 2'b00;
    assign alu_src_a     = rst_n ? alu_src_a_d  : 2'b00;
    assign alu_src_b     = rst_n ? alu_src_b_d  : 2'b00;
    assign alu_op        = rst_n ? alu_op_d     : 2'b00;
    assign imm_src       = rst_n ? imm_src_d    : 2'b00;
    assign state_dbg     = STATE_WIDTH'(state);

endmodule
